// File: rtl/cues_rx_pkg.sv
// cues_rx_pkg: shared types and defaults for the CUES clocked receiver.
// FSM state encoding, drop counter width, default payload/FIFO sizes.
package cues_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rx_state_e;

  localparam int DROP_W     = 16;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/cues_sync_receiver_if.sv
// cues_sync_receiver_if: upstream SEND/ACK bundle plus the
// downstream valid/ready stream and status of the receiver.
interface cues_sync_receiver_if #(
  parameter int DATA_W = cues_rx_pkg::DEF_DATA_W,
  parameter int DEPTH  = cues_rx_pkg::DEF_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                           sendin;
  logic                           exbin;
  logic [DATA_W-1:0]              datain;
  logic                           ackout;
  logic                           out_valid;
  logic                           out_ready;
  logic [DATA_W-1:0]              out_data;
  logic [CNT_W-1:0]               count;
  logic [cues_rx_pkg::DROP_W-1:0] drop_cnt;

  modport master (
    output sendin, exbin, datain, out_ready,
    input  ackout, out_valid, out_data,
    input  count, drop_cnt
  );

  modport slave (
    input  sendin, exbin, datain, out_ready,
    output ackout, out_valid, out_data,
    output count, drop_cnt
  );

endinterface

// File: rtl/cues_rx_fifo.sv
// cues_rx_fifo: synchronous power-of-two FIFO with occupancy count.
// Caller must not push when full; pops on empty are ignored.
module cues_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic                     valid,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       cnt;
  logic              do_pop;

  assign valid  = (cnt != '0);
  assign do_pop = pop & valid;
  assign dout   = mem[rptr];
  assign count  = cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      unique case ({push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cues_sync_receiver.sv
// cues_sync_receiver: four-phase SEND/ACK sink to valid/ready stream.
// CUES_RX_DROP_CNT_EN compiles in the saturating dropped-token counter.
module cues_sync_receiver
  import cues_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input logic                  clk,
  input logic                  reset,
  cues_sync_receiver_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             send_q1;
  logic             send_s;
  rx_state_e        state_q;
  rx_state_e        state_d;
  logic             take;
  logic             push;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      send_q1 <= 1'b0;
      send_s  <= 1'b0;
    end else begin
      send_q1 <= bus.sendin;
      send_s  <= send_q1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Full check uses registered count: a same-cycle pop frees nothing.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (send_s &&
            (!bus.exbin || count < CNT_W'(DEPTH))) begin
          take    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!send_s) state_d = IDLE;
      end
    endcase
  end

  assign push       = take & bus.exbin;
  assign bus.ackout = (state_q == ACK);
  assign bus.count  = count;

  cues_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (bus.datain),
    .pop   (bus.out_ready),
    .valid (bus.out_valid),
    .dout  (bus.out_data),
    .count (count)
  );

`ifdef CUES_RX_DROP_CNT_EN
  logic              drop;
  logic [DROP_W-1:0] drop_q;

  assign drop = take & ~bus.exbin;

  always_ff @(posedge clk) begin
    if (reset)
      drop_q <= '0;
    else if (drop && drop_q != '1)
      drop_q <= drop_q + 1'b1;
  end

  assign bus.drop_cnt = drop_q;
`else
  assign bus.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_cues_sync_receiver.sv
// tb_cues_sync_receiver: scoreboard bench for the CUES receiver.
// Handshake tasks drive upstream; a monitor checks the output stream.
module tb_cues_sync_receiver;
  import cues_rx_pkg::*;

  localparam int DW = 8;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cues_sync_receiver_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  cues_sync_receiver #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  int exp_drop = 0;
  int cyc = 0;
  logic [DW-1:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pops happen on the next posedge; inputs change only at posedge+1.
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: got %h, required none",
                 bus.out_data);
      end else begin
        logic [DW-1:0] exp;
        exp = sb.pop_front();
        if (bus.out_data !== exp) begin
          miscompares++;
          $display("FAIL pop_data: got %h, required %h",
                   bus.out_data, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input logic [DW-1:0] d, input logic e);
    bus.datain = d;
    bus.exbin  = e;
    bus.sendin = 1'b1;
    if (e) sb.push_back(d);
  endtask

  task automatic wait_ack(input logic lvl, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.ackout === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic e,
                      output int nr, output int nf);
    raise(d, e);
    wait_ack(1'b1, nr);
    bus.sendin = 1'b0;
    wait_ack(1'b0, nf);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    vectors++;
    if (sb.size() !== 0 || bus.count !== 3'd0) begin
      miscompares++;
      $display("FAIL drain: got left=%0d count=%0d, required 0/0",
               sb.size(), bus.count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.sendin = 1'b0;
    bus.exbin = 1'b0;
    bus.datain = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    vectors++;
    if (bus.ackout !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.count !== 3'd0 || bus.drop_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state: got ack=%b v=%b c=%0d d=%0d, required 0",
               bus.ackout, bus.out_valid, bus.count, bus.drop_cnt);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_keep();
    int nr, nf;
    bus.out_ready = 1'b1;
    raise(8'hA5, 1'b1);
    wait_ack(1'b1, nr);
    vectors++;
    if (nr < 2 || nr > 4) begin
      miscompares++;
      $display("FAIL keep_ack_rise: got %0d edges, required 3+-1", nr);
    end
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL keep_head: got v=%b d=%h, required 1/a5",
               bus.out_valid, bus.out_data);
    end
    bus.sendin = 1'b0;
    wait_ack(1'b0, nf);
    vectors++;
    if (nf < 2 || nf > 4) begin
      miscompares++;
      $display("FAIL keep_ack_fall: got %0d edges, required 3+-1", nf);
    end
  endtask

  task automatic test_drop();
    int nr, nf;
    bus.out_ready = 1'b1;
    send(8'h3C, 1'b0, nr, nf);
`ifdef CUES_RX_DROP_CNT_EN
    exp_drop++;
`endif
    vectors++;
    if (nr < 2 || nr > 4 || nf < 2 || nf > 4) begin
      miscompares++;
      $display("FAIL drop_handshake: got rise=%0d fall=%0d, required 3+-1",
               nr, nf);
    end
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 ||
        bus.drop_cnt !== 16'(exp_drop)) begin
      miscompares++;
      $display("FAIL drop_state: got v=%b c=%0d d=%0d, required 0/0/%0d",
               bus.out_valid, bus.count, bus.drop_cnt, exp_drop);
    end
  endtask

  task automatic test_backpressure();
    int nr, nf;
    logic acked;
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), 1'b1, nr, nf);
      vectors++;
      if (nr < 2 || nr > 4) begin
        miscompares++;
        $display("FAIL bp_ack_%0d: got %0d edges, required 3+-1", i, nr);
      end
    end
    vectors++;
    if (bus.count !== 3'd4) begin
      miscompares++;
      $display("FAIL bp_count: got %0d, required 4", bus.count);
    end
    raise(8'h05, 1'b1);
    acked = 1'b0;
    repeat (10) begin
      tick();
      if (bus.ackout !== 1'b0) acked = 1'b1;
    end
    vectors++;
    if (acked !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full_noack: got ack=%b, required 0", acked);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    wait_ack(1'b1, nr);
    vectors++;
    if (nr < 1 || nr > 4) begin
      miscompares++;
      $display("FAIL bp_ack_after_pop: got %0d edges, required 1..4", nr);
    end
    bus.sendin = 1'b0;
    wait_ack(1'b0, nf);
    drain();
  endtask

  task automatic test_full_drop();
    int nr, nf;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1'b1, nr, nf);
    send(8'h77, 1'b0, nr, nf);
`ifdef CUES_RX_DROP_CNT_EN
    exp_drop++;
`endif
    vectors++;
    if (nr < 2 || nr > 4) begin
      miscompares++;
      $display("FAIL full_drop_ack: got %0d edges, required 3+-1", nr);
    end
    vectors++;
    if (bus.count !== 3'd4 || bus.drop_cnt !== 16'(exp_drop)) begin
      miscompares++;
      $display("FAIL full_drop_state: got c=%0d d=%0d, required 4/%0d",
               bus.count, bus.drop_cnt, exp_drop);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int nr, nf;
    bus.out_ready = 1'b0;
    send(8'h21, 1'b1, nr, nf);
    raise(8'h22, 1'b1);
    wait_ack(1'b1, nr);
    vectors++;
    if (bus.ackout !== 1'b1 || bus.count !== 3'd2) begin
      miscompares++;
      $display("FAIL rst_pre: got ack=%b c=%0d, required 1/2",
               bus.ackout, bus.count);
    end
    reset = 1'b1;
    bus.sendin = 1'b0;
    tick();
    vectors++;
    if (bus.ackout !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.count !== 3'd0 || bus.drop_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_mid: got ack=%b v=%b c=%0d d=%0d, required 0",
               bus.ackout, bus.out_valid, bus.count, bus.drop_cnt);
    end
    reset = 1'b0;
    sb.delete();
    exp_drop = 0;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    int nr, nf, rise, prev;
    prev = -1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      raise(8'($urandom_range(0, 255)), 1'b1);
      wait_ack(1'b1, nr);
      rise = cyc;
      vectors++;
      if (nr < 2 || nr > 4) begin
        miscompares++;
        $display("FAIL b2b_ack_%0d: got %0d edges, required 3+-1", i, nr);
      end
      if (prev >= 0) begin
        vectors++;
        if (rise - prev < 6) begin
          miscompares++;
          $display("FAIL b2b_gap_%0d: got %0d, required >=6",
                   i, rise - prev);
        end
      end
      prev = rise;
      bus.sendin = 1'b0;
      wait_ack(1'b0, nf);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_keep();
    test_drop();
    test_backpressure();
    test_full_drop();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cues_sync_receiver.md
# cues_sync_receiver

Clocked sink for the self-timed CUES token pipeline: terminates the four-phase SEND/ACK bundled-data handshake produced by a C-element stage and delivers tokens to synchronous logic as a valid/ready stream. Tokens marked non-exclusive (EXB=0) are acknowledged and discarded, matching the sender-side mask semantics. Sits at the async-to-sync boundary, between the last C-element stage and clocked consumers.

## Interface
- DATA_W, 8, token payload width
- DEPTH, 4, receive FIFO entries (power of two, ≥2)
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- SENDIN  input  1  asynchronous request from upstream C-element stage
- EXBIN  input  1  branch flag bundled with SENDIN; 1 = keep token, 0 = drop
- DATAIN  input  DATA_W  bundled payload, stable from SENDIN rise until ACKOUT rise
- ACKOUT  output  1  registered acknowledge to upstream
- OUT_VALID  output  1  FIFO head valid
- OUT_READY  input  1  consumer accepts head
- OUT_DATA  output  DATA_W  FIFO head payload
- COUNT  output  log2(DEPTH)+1  FIFO occupancy
- DROP_CNT  output  16  dropped-token count (see Configuration)

## Operation
- SENDIN passes through a two-flop synchronizer (send_s); EXBIN and DATAIN are sampled unsynchronized only when send_s=1 (bundled-data guarantee).
- FSM states: IDLE, ACK.
  - IDLE, ACKOUT=0: if send_s=1 and (EXB=0 or COUNT<DEPTH): push DATAIN when EXB=1, else discard and increment DROP_CNT; go ACK. If FIFO full and EXB=1: stay in IDLE, no ack (back-pressure).
  - ACK, ACKOUT=1: when send_s=0 go IDLE.
- Full test uses registered COUNT only; a same-cycle pop does not free a slot for a push (no pass-through).
- FIFO: push at tail, pop on OUT_VALID & OUT_READY; simultaneous push/pop keeps COUNT unchanged; pointers wrap mod DEPTH; OUT_DATA undefined when OUT_VALID=0.
- Reset values: ACKOUT=0, OUT_VALID=0, COUNT=0, DROP_CNT=0, FSM=IDLE, synchronizer=0.
- Reset mid-handshake: ACKOUT drops next edge, FIFO contents lost. If SENDIN is still high after reset release, it is treated as a new token; upstream must be reset concurrently.

## Timing
- SENDIN rise to ACKOUT rise: 3 CLK edges (2 sync + FSM register), +1 edge for metastability resolution.
- SENDIN fall to ACKOUT fall: 3 CLK edges, same tolerance.
- Push to OUT_VALID: 1 edge (registered FIFO output).
- Peak throughput: one token per 6 CLK cycles, set by the handshake round trip.
- No combinational path from any input to any output.

## Configuration
- CUES_RX_DROP_CNT_EN defined: DROP_CNT increments on every EXB=0 token acknowledged and saturates at 0xFFFF. Cleared only by RESET.
- Not defined: counter logic is not compiled in, and DROP_CNT is tied to 0.

## Structure
- Package cues_rx_pkg: FSM state enum (IDLE, ACK), DROP_CNT width constant, default DATA_W/DEPTH.
- Sub-module cues_rx_fifo: synchronous FIFO with push/pop/count. Synchronizer and FSM are inline in the top module.

## Test plan
- Single keep token EXB=1, DATAIN=0xA5, OUT_READY=1 -> ACKOUT rises 3±1 edges after SENDIN rises; OUT_VALID=1 with OUT_DATA=0xA5 one edge after the push; ACKOUT falls 3±1 edges after SENDIN falls.
- Drop token EXB=0, DATAIN=0x3C -> full handshake completes, OUT_VALID stays 0, COUNT=0, DROP_CNT=1 (macro on) or 0 (macro off).
- Back-pressure with OUT_READY=0: tokens 0x01–0x04 are acked and COUNT=4; the 5th token (0x05) gets no ACKOUT. After one pop, 0x05 is acked; drain order is 01,02,03,04,05.
- Full FIFO plus EXB=0 token -> token is acked and dropped, COUNT stays 4.
- RESET asserted one cycle while ACKOUT=1 and COUNT=2 -> next edge ACKOUT=0, OUT_VALID=0, COUNT=0, DROP_CNT=0.
- 16 back-to-back keep tokens with random payloads and OUT_READY=1 -> all received in order; the gap between successive ACKOUT rises is ≥6 cycles.
